// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer.
package note_seq_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int NOTE_W_DEF = 6;
   localparam int DUR_W_DEF  = 6;

   // A ROM slot whose duration field holds this value marks the end of the song.
   localparam int END_DUR = 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_PLAY  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/note_seq_ctrl_dur_counter.sv
// Beat down-counter for the note currently sounding.
// Restart clear wins over load, load wins over decrement; decrement stops at zero.
module dur_counter
   import note_seq_pkg::*;
#(
   parameter int DUR_W = DUR_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [DUR_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o,
   output logic             one_o
);

   logic [DUR_W-1:0] cnt_q, cnt_d;

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // Next count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                         cnt_d = '0;
      else if (load_i)                   cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))   cnt_d = cnt_q - DUR_W'(1);
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == DUR_W'(1));

endmodule

// File: rtl/note_seq_ctrl.sv
// Note sequencer: fetches {note, duration} slots from a song ROM and plays
// each note for its duration in beats from an external beat counter.
// Build option NOTE_GAP_EN: when defined, every note end spends one cycle in
// GAP (note silent) before fetching the next slot; otherwise it goes straight
// to FETCH and GAP is never entered.
//
// state | meaning
// IDLE  | waiting for play; beat counter held clear
// FETCH | ROM request outstanding at rom_addr
// LOAD  | examine fetched slot; end marker or start of note
// PLAY  | note sounding while play=1; paused (silent, beats ignored) while play=0
// GAP   | one-cycle articulation silence between notes
// DONE  | song finished; waits for restart
module note_seq_ctrl
   import note_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int DUR_W  = DUR_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    play,
   input  logic                    restart,
   input  logic                    beat_done,
   output logic                    beat_clr,
   output logic                    rom_req,
   input  logic                    rom_ack,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [NOTE_W+DUR_W-1:0] rom_data,
   output logic [NOTE_W-1:0]       note,
   output logic                    note_valid,
   output logic                    new_note,
   output logic                    song_done
);

`ifdef NOTE_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   state_e                    state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [NOTE_W+DUR_W-1:0]   data_q, data_d;
   logic [NOTE_W-1:0]         note_q, note_d;
   logic                      new_note_q, new_note_d;

   logic                      dur_clr, dur_load, dur_dec;
   logic                      dur_zero, dur_one;
   logic [DUR_W-1:0]          slot_dur;
   logic [NOTE_W-1:0]         slot_note;

   assign slot_dur  = data_q[DUR_W-1:0];
   assign slot_note = data_q[DUR_W +: NOTE_W];

   dur_counter #(.DUR_W(DUR_W)) u_dur (
      .clk_i      (clk),
      .rst_ni     (rst),
      .clr_i      (dur_clr),
      .load_i     (dur_load),
      .load_val_i (slot_dur),
      .dec_i      (dur_dec),
      .zero_o     (dur_zero),
      .one_o      (dur_one)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         note_q     <= '0;
         new_note_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         note_q     <= note_d;
         new_note_q <= new_note_d;
      end
   end

   // Next-state and datapath control; restart overrides every state.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      note_d     = note_q;
      new_note_d = 1'b0;
      dur_clr    = 1'b0;
      dur_load   = 1'b0;
      dur_dec    = 1'b0;
      if (restart) begin
         state_d = S_IDLE;
         addr_d  = '0;
         note_d  = '0;
         dur_clr = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (play) state_d = S_FETCH;
            end
            S_FETCH: begin
               if (rom_ack) begin
                  data_d  = rom_data;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (slot_dur == DUR_W'(END_DUR)) begin
                  state_d = S_DONE;
               end else begin
                  dur_load   = 1'b1;
                  note_d     = slot_note;
                  new_note_d = 1'b1;
                  state_d    = S_PLAY;
               end
            end
            S_PLAY: begin
               if (play && beat_done) begin
                  dur_dec = 1'b1;
                  // zero only guards against a corrupted count; it cannot hang the note
                  if (dur_one || dur_zero) begin
                     if (addr_q == '1) begin
                        state_d = S_DONE;
                     end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = GAP_EN ? S_GAP : S_FETCH;
                     end
                  end
               end
            end
            S_GAP:   state_d = S_FETCH;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      rom_req    = (state_q == S_FETCH);
      note_valid = (state_q == S_PLAY) && play;
      song_done  = (state_q == S_DONE);
      beat_clr   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_LOAD) ||
                   ((state_q == S_PLAY) && !play);
   end

   assign rom_addr = addr_q;
   assign note     = note_q;
   assign new_note = new_note_q;

endmodule
